// File: rtl/rectangle_pkg.sv
// Shared definitions for the RECTANGLE-128 sequencer.
// Holds the FSM state encoding, the operand widths and the default
// watchdog configuration.
package rectangle_pkg;

    localparam int BLOCK_W     = 64;   // plaintext / ciphertext width
    localparam int KEY_W       = 128;  // key width
    localparam int DEF_TIMEOUT = 64;   // default watchdog limit in RUN cycles
    localparam int DEF_CNT_W   = 7;    // default watchdog counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rectangle_wdt.sv
// Watchdog counter for the wait on the core's done pulse.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   clear      : restart the count at zero (job accepted)
//   enable     : count this cycle (controller in RUN)
//   expire     : count has reached P_TIMEOUT-1
// The counter saturates at P_TIMEOUT-1, so it can never wrap and hide
// a hung core. 2**P_CNT_W must exceed P_TIMEOUT.
module rectangle_wdt #(
    parameter int P_TIMEOUT = 64,
    parameter int P_CNT_W   = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [P_CNT_W-1:0] LIMIT = P_CNT_W'(P_TIMEOUT - 1);

    logic [P_CNT_W-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == LIMIT);

endmodule

// File: rtl/rectangle_ctrl.sv
// Sequencer in front of the round-based RECTANGLE-128 core.
// Ports:
//   i_clk, i_rst_n          : clock, synchronous active-low reset
//   i_req_valid/o_req_ready : request handshake, carries iv_plaintext/iv_key
//   o_rsp_valid/i_rsp_ready : response handshake, carries ov_ciphertext and
//                             o_rsp_error (watchdog abort, data forced to 0)
//   o_busy                  : controller is not idle
//   o_core_enable           : level enable held high for the whole encryption
//   ov_core_plaintext/key   : registered operands presented to the core
//   i_core_done/iv_core_data: core completion pulse and result
module rectangle_ctrl
    import rectangle_pkg::*;
#(
    parameter int P_TIMEOUT = DEF_TIMEOUT,
    parameter int P_CNT_W   = DEF_CNT_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [BLOCK_W-1:0] iv_plaintext,
    input  logic [KEY_W-1:0]   iv_key,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [BLOCK_W-1:0] ov_ciphertext,
    output logic               o_rsp_error,
    output logic               o_busy,
    output logic               o_core_enable,
    output logic [BLOCK_W-1:0] ov_core_plaintext,
    output logic [KEY_W-1:0]   ov_core_key,
    input  logic               i_core_done,
    input  logic [BLOCK_W-1:0] iv_core_data
);

    state_t             state;
    state_t             next_state;
    logic               ready_q;   // low on the reset edge, high one cycle after release
    logic               accept;
    logic               expire;
    logic [BLOCK_W-1:0] pt_q;
    logic [KEY_W-1:0]   key_q;
    logic [BLOCK_W-1:0] ct_q;
    logic               err_q;

    rectangle_wdt #(
        .P_TIMEOUT (P_TIMEOUT),
        .P_CNT_W   (P_CNT_W)
    ) u_wdt (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .clear  (accept),
        .enable (state == RUN),
        .expire (expire)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= 1'b1;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        next_state    = state;
        accept        = 1'b0;
        o_req_ready   = 1'b0;
        o_core_enable = 1'b0;
        o_rsp_valid   = 1'b0;
        o_busy        = 1'b1;
        case (state)
            IDLE: begin
                o_busy      = 1'b0;
                o_req_ready = ready_q;
                accept      = ready_q && i_req_valid;
                if (accept) next_state = RUN;
            end
            RUN: begin
                o_core_enable = 1'b1;
                // Done is checked first so it wins over a simultaneous expiry.
                if (i_core_done || expire) next_state = RESP;
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pt_q  <= '0;
            key_q <= '0;
            ct_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                pt_q  <= iv_plaintext;
                key_q <= iv_key;
            end
            if (state == RUN) begin
                if (i_core_done) begin
                    ct_q  <= iv_core_data;
                    err_q <= 1'b0;
                end else if (expire) begin
                    ct_q  <= '0;
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign ov_core_plaintext = pt_q;
    assign ov_core_key       = key_q;
    assign ov_ciphertext     = ct_q;
    assign o_rsp_error       = err_q;

endmodule
